// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: clips a rectangle to the visible frame and streams
// one pixel write per cycle, row-major, into the OSD frame buffer.
//
// state | meaning
// IDLE  | waiting for iSTART, parameters latched on start
// SETUP | clip, empty check, first-row base address
// WRITE | one write presented per cycle, advances on accept
// DONE  | one-cycle completion pulse
module vga_rect_fill #(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int ADDR_W = 19
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iSTART,
   input  logic [9:0]        iX0,
   input  logic [9:0]        iY0,
   input  logic [9:0]        iW,
   input  logic [9:0]        iH,
   input  logic [15:0]       iCOLOR,
   input  logic              iWAIT,
   output logic [ADDR_W-1:0] oADDR,
   output logic [15:0]       oDATA,
   output logic              oWR,
   output logic              oCS,
   output logic              oBUSY,
   output logic              oDONE
);

   localparam logic [10:0]       H_END  = 11'(H_RES);
   localparam logic [10:0]       V_END  = 11'(V_RES);
   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_RES);

   typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;

   state_t              state;
   logic [9:0]          x0, y0, w, h;
   logic [9:0]          col, row;
   logic [10:0]         xEnd, yEnd;
   logic [ADDR_W-1:0]   rowBase;

   logic [10:0]         xSum, ySum, xClip, yClip;
   logic [10:0]         colNext, rowNext;
   logic                empty, colLast, rowLast;
   logic [ADDR_W-1:0]   baseY;

   // Clip in 11 bits so x0+w cannot wrap before the comparison.
   assign xSum    = {1'b0, x0} + {1'b0, w};
   assign ySum    = {1'b0, y0} + {1'b0, h};
   assign xClip   = (xSum > H_END) ? H_END : xSum;
   assign yClip   = (ySum > V_END) ? V_END : ySum;
   assign empty   = (w == 10'd0) || (h == 10'd0) ||
                    ({1'b0, x0} >= H_END) || ({1'b0, y0} >= V_END);
   assign colNext = {1'b0, col} + 11'd1;
   assign rowNext = {1'b0, row} + 11'd1;
   assign colLast = (colNext == xEnd);
   assign rowLast = (rowNext == yEnd);

   generate
      if (H_RES == 640) begin : gShiftBase
         assign baseY = (ADDR_W'(y0) << 9) + (ADDR_W'(y0) << 7);
      end else begin : gMulBase
         assign baseY = ADDR_W'(y0) * STRIDE;
      end
   endgenerate

   assign oCS = oWR;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state   <= IDLE;
         x0      <= '0;
         y0      <= '0;
         w       <= '0;
         h       <= '0;
         col     <= '0;
         row     <= '0;
         xEnd    <= '0;
         yEnd    <= '0;
         rowBase <= '0;
         oADDR   <= '0;
         oDATA   <= '0;
         oWR     <= 1'b0;
         oBUSY   <= 1'b0;
         oDONE   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               oDONE <= 1'b0;
               if (iSTART) begin
                  x0    <= iX0;
                  y0    <= iY0;
                  w     <= iW;
                  h     <= iH;
                  oDATA <= iCOLOR;
                  oBUSY <= 1'b1;
                  state <= SETUP;
               end
            end
            SETUP: begin
               if (empty) begin
                  oBUSY <= 1'b0;
                  oDONE <= 1'b1;
                  state <= DONE;
               end else begin
                  xEnd    <= xClip;
                  yEnd    <= yClip;
                  rowBase <= baseY;
                  col     <= x0;
                  row     <= y0;
                  oADDR   <= baseY + ADDR_W'(x0);
                  oWR     <= 1'b1;
                  state   <= WRITE;
               end
            end
            WRITE: begin
               if (!iWAIT) begin
                  if (colLast && rowLast) begin
                     oWR   <= 1'b0;
                     oBUSY <= 1'b0;
                     oDONE <= 1'b1;
                     state <= DONE;
                  end else if (colLast) begin
                     col     <= x0;
                     row     <= row + 10'd1;
                     rowBase <= rowBase + STRIDE;
                     oADDR   <= rowBase + STRIDE + ADDR_W'(x0);
                  end else begin
                     col   <= col + 10'd1;
                     oADDR <= oADDR + ADDR_W'(1);
                  end
               end
            end
            DONE: begin
               oDONE <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Bench for vga_rect_fill: directed and random rectangles compared cycle by
// cycle against a pixel list built from the clip rules.
module tb_vga_rect_fill;

   logic        iCLK = 1'b0;
   logic        iRST, iSTART, iWAIT;
   logic [9:0]  iX0, iY0, iW, iH;
   logic [15:0] iCOLOR;
   logic [18:0] oADDR;
   logic [15:0] oDATA;
   logic        oWR, oCS, oBUSY, oDONE;

   int errors = 0;
   int checks = 0;

   vga_rect_fill dut (
      .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART),
      .iX0(iX0), .iY0(iY0), .iW(iW), .iH(iH), .iCOLOR(iCOLOR), .iWAIT(iWAIT),
      .oADDR(oADDR), .oDATA(oDATA), .oWR(oWR), .oCS(oCS),
      .oBUSY(oBUSY), .oDONE(oDONE)
   );

   always #5 iCLK = ~iCLK;

   initial begin
      #3000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after DONE.
   task automatic runRect(input int x0, input int y0, input int w, input int h,
                          input logic [15:0] color, input int stallMode,
                          input bit busyStart);
      int q[$];
      int xe, ye, idx, stalls, cyc, stallLeft;
      bit stalledOnce;
      xe = (x0 + w > 640) ? 640 : x0 + w;
      ye = (y0 + h > 480) ? 480 : y0 + h;
      for (int r = y0; r < ye; r++)
         for (int c = x0; c < xe; c++)
            q.push_back(r * 640 + c);

      iSTART = 1'b1; iX0 = 10'(x0); iY0 = 10'(y0); iW = 10'(w); iH = 10'(h);
      iCOLOR = color; iWAIT = 1'b0;
      @(negedge iCLK);
      check("setup_busy", oBUSY, 1);
      check("setup_wr", oWR, 0);
      check("setup_done", oDONE, 0);
      iSTART = 1'b0;
      iX0 = 10'($urandom); iY0 = 10'($urandom); iW = 10'($urandom);
      iH = 10'($urandom); iCOLOR = 16'($urandom);
      idx = 0; stalls = 0; cyc = 2; stallLeft = 0; stalledOnce = 0;
      @(negedge iCLK);
      while (idx < q.size() && cyc < 4000) begin
         check("wr", oWR, 1);
         check("cs", oCS, 1);
         check("addr", oADDR, q[idx]);
         check("data", oDATA, color);
         check("busy", oBUSY, 1);
         check("done_early", oDONE, 0);
         if (stallMode == 2 && idx == 1 && !stalledOnce) begin
            stallLeft = 3;
            stalledOnce = 1;
         end
         if (stallMode == 2) iWAIT = (stallLeft > 0);
         else if (stallMode == 1) iWAIT = ($urandom_range(0, 2) == 0);
         else iWAIT = 1'b0;
         if (stallLeft > 0) stallLeft--;
         if (iWAIT) stalls++;
         else idx++;
         iSTART = busyStart && ($urandom_range(0, 3) == 0);
         if (iSTART) begin
            iX0 = 10'($urandom_range(0, 20)); iY0 = 10'($urandom_range(0, 20));
            iW = 10'($urandom_range(1, 8)); iH = 10'($urandom_range(1, 8));
            iCOLOR = 16'($urandom);
         end
         @(negedge iCLK);
         cyc++;
      end
      if (idx < q.size()) check("write_timeout", idx, q.size());
      iSTART = 1'b0; iWAIT = 1'b0;
      check("done_pulse", oDONE, 1);
      check("done_wr", oWR, 0);
      check("done_busy", oBUSY, 0);
      check("done_cycle", cyc, q.size() + 2 + stalls);
      @(negedge iCLK);
      check("idle_done", oDONE, 0);
      check("idle_busy", oBUSY, 0);
      check("idle_wr", oWR, 0);
   endtask

   initial begin
      iRST = 1'b1; iSTART = 1'b0; iWAIT = 1'b0;
      iX0 = '0; iY0 = '0; iW = '0; iH = '0; iCOLOR = '0;
      repeat (2) @(negedge iCLK);
      check("rst_addr", oADDR, 0);
      check("rst_data", oDATA, 0);
      check("rst_wr", oWR, 0);
      check("rst_cs", oCS, 0);
      check("rst_busy", oBUSY, 0);
      check("rst_done", oDONE, 0);
      iRST = 1'b0;
      @(negedge iCLK);

      runRect(1, 1, 2, 2, 16'h0001, 0, 0);       // basic 2x2
      runRect(638, 479, 5, 3, 16'hBEEF, 0, 0);   // clipped to two pixels
      runRect(10, 10, 0, 4, 16'h1234, 0, 0);     // zero width
      runRect(640, 10, 4, 4, 16'h1234, 0, 0);    // off right edge
      runRect(5, 480, 4, 4, 16'h1234, 0, 0);     // off bottom edge
      runRect(0, 0, 4, 1, 16'hA5A5, 2, 0);       // 3-cycle stall on 2nd write
      runRect(630, 2, 12, 3, 16'h5A5A, 0, 1);    // starts while busy ignored

      // Reset after five accepted writes of a 10x10 fill.
      iSTART = 1'b1; iX0 = 10'd100; iY0 = 10'd50; iW = 10'd10; iH = 10'd10;
      iCOLOR = 16'h7777; iWAIT = 1'b0;
      @(negedge iCLK);
      iSTART = 1'b0;
      repeat (6) @(negedge iCLK);
      check("mid_wr", oWR, 1);
      check("mid_addr", oADDR, 50 * 640 + 105);
      iRST = 1'b1;
      @(negedge iCLK);
      check("abort_wr", oWR, 0);
      check("abort_busy", oBUSY, 0);
      check("abort_done", oDONE, 0);
      check("abort_addr", oADDR, 0);
      iRST = 1'b0;
      repeat (3) begin
         @(negedge iCLK);
         check("post_abort_done", oDONE, 0);
         check("post_abort_wr", oWR, 0);
      end
      runRect(5, 5, 1, 1, 16'hC0DE, 0, 0);

      for (int n = 0; n < 30; n++) begin
         int rx, ry;
         rx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 1023) : $urandom_range(620, 645);
         ry = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 1023) : $urandom_range(460, 485);
         runRect(rx, ry, $urandom_range(0, 14), $urandom_range(0, 6),
                 16'($urandom), 1, $urandom_range(0, 1) == 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
